// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: samples VGA syncs/RGB on pixel enables, recovers pixel coordinates,
// checks line/frame lengths, tracks lock and keeps a saturating error count.
module vga_sync_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       vga_h_sync,
  input  logic       vga_v_sync,
  input  logic [2:0] vga_rgb,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic       rx_active,
  output logic [2:0] rx_rgb,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_count
);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS0     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] HS1     = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] VS0     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] VS1     = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {UNLOCK = 2'd0, ACQ = 2'd1, LOCK = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic       vs_pend_q, vs_pend_d, h_arm_q, h_arm_d, v_arm_q, v_arm_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic [2:0] rx_rgb_q, rx_rgb_d;
  logic       rx_active_q, rx_active_d, locked_q, locked_d;
  logic       frame_start_q, h_err_q, v_err_q;
  logic [7:0] err_count_q, err_count_d;
  logic       hs_s, vs_s, hs_edge, vs_edge, pend_now, fs_now, herr_now, verr_now, win;

  always_comb begin
    hs_s     = (SYNC_POL != 0) ? vga_h_sync : !vga_h_sync;
    vs_s     = (SYNC_POL != 0) ? vga_v_sync : !vga_v_sync;
    hs_edge  = hs_s && !hs_prev_q;
    vs_edge  = vs_s && !vs_prev_q;
    // a vsync edge coinciding with an hsync edge is consumed by that same hsync edge
    pend_now = vs_pend_q || vs_edge;
    fs_now   = hs_edge && pend_now;
    herr_now = hs_edge && h_arm_q && (hcnt_q != H_LAST);
    verr_now = fs_now && v_arm_q && (vcnt_q != V_LAST);

    hs_prev_d = hs_s;
    vs_prev_d = vs_s;
    vs_pend_d = pend_now && !hs_edge;
    h_arm_d   = h_arm_q || hs_edge;
    v_arm_d   = v_arm_q || fs_now;

    hcnt_d = hs_edge ? 10'd0 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1);
    vcnt_d = vcnt_q;
    if (fs_now) begin
      vcnt_d = 10'd0;
    end else if (hs_edge && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end

    state_d = state_q;
    case (state_q)
      UNLOCK:  if (fs_now) state_d = ACQ;
      ACQ:     if (fs_now) state_d = LOCK;
      default: state_d = LOCK;
    endcase
    // an error always wins and re-arms the first-edge suppression of both checks
    if (herr_now || verr_now) begin
      state_d = UNLOCK;
      h_arm_d = 1'b0;
      v_arm_d = 1'b0;
    end
    locked_d = (state_d == LOCK);

    err_count_d = err_count_q;
    if ((herr_now || verr_now) && (err_count_q != 8'hff)) begin
      err_count_d = err_count_q + 8'd1;
    end

    win = locked_d && (hcnt_d >= HS0) && (hcnt_d < HS1) && (vcnt_d >= VS0) && (vcnt_d < VS1);
    rx_active_d = win;
    rx_x_d      = win ? hcnt_d - HS0 : 10'd0;
    rx_y_d      = win ? vcnt_d - VS0 : 10'd0;
    rx_rgb_d    = win ? vga_rgb : 3'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= UNLOCK;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      vs_pend_q     <= 1'b0;
      h_arm_q       <= 1'b0;
      v_arm_q       <= 1'b0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      rx_x_q        <= 10'd0;
      rx_y_q        <= 10'd0;
      rx_rgb_q      <= 3'd0;
      rx_active_q   <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      err_count_q   <= 8'd0;
    end else if (pix_en) begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      vs_pend_q     <= vs_pend_d;
      h_arm_q       <= h_arm_d;
      v_arm_q       <= v_arm_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      rx_x_q        <= rx_x_d;
      rx_y_q        <= rx_y_d;
      rx_rgb_q      <= rx_rgb_d;
      rx_active_q   <= rx_active_d;
      locked_q      <= locked_d;
      frame_start_q <= fs_now;
      h_err_q       <= herr_now;
      v_err_q       <= verr_now;
      err_count_q   <= err_count_d;
    end else begin
      frame_start_q <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
    end
  end

  assign rx_x        = rx_x_q;
  assign rx_y        = rx_y_q;
  assign rx_active   = rx_active_q;
  assign rx_rgb      = rx_rgb_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign err_count   = err_count_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: scaled-down timing, an active-low and an active-high instance
// fed the same video, a per-sample scoreboard plus frame-level vector table and corner sequences.
module tb_vga_sync_monitor;
  localparam int HT = 24, HSY = 3, HBK = 4, HA = 14;
  localparam int VT = 14, VSY = 2, VBK = 3, VA = 7;
  localparam int HS0 = HSY + HBK, VS0 = VSY + VBK;

  logic       clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
  logic       hs_n = 1'b1, vs_n = 1'b1, hs_p = 1'b0, vs_p = 1'b0;
  logic [2:0] rgb = 3'd0;

  logic [9:0] n_x, n_y, p_x, p_y;
  logic [2:0] n_rgb, p_rgb;
  logic       n_act, n_fs, n_lk, n_he, n_ve, p_act, p_fs, p_lk, p_he, p_ve;
  logic [7:0] n_ec, p_ec;

  vga_sync_monitor #(.H_TOTAL(HT), .H_SYNC(HSY), .H_BACK(HBK), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VSY), .V_BACK(VBK), .V_ACTIVE(VA), .SYNC_POL(0)) dut_n (
    .clk(clk), .reset(rst), .pix_en(pix_en), .vga_h_sync(hs_n), .vga_v_sync(vs_n),
    .vga_rgb(rgb), .rx_x(n_x), .rx_y(n_y), .rx_active(n_act), .rx_rgb(n_rgb),
    .frame_start(n_fs), .locked(n_lk), .h_err(n_he), .v_err(n_ve), .err_count(n_ec));

  vga_sync_monitor #(.H_TOTAL(HT), .H_SYNC(HSY), .H_BACK(HBK), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VSY), .V_BACK(VBK), .V_ACTIVE(VA), .SYNC_POL(1)) dut_p (
    .clk(clk), .reset(rst), .pix_en(pix_en), .vga_h_sync(hs_p), .vga_v_sync(vs_p),
    .vga_rgb(rgb), .rx_x(p_x), .rx_y(p_y), .rx_active(p_act), .rx_rgb(p_rgb),
    .frame_start(p_fs), .locked(p_lk), .h_err(p_he), .v_err(p_ve), .err_count(p_ec));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic [2:0] rgb;
    logic       fs;
    logic       lk;
    logic       he;
    logic       ve;
    logic [7:0] ec;
  } obs_t;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  task automatic cmp(input string name, input obs_t got, input obs_t want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
  endtask

  function automatic obs_t pack_n();
    obs_t o;
    o.x = n_x; o.y = n_y; o.act = n_act; o.rgb = n_rgb; o.fs = n_fs;
    o.lk = n_lk; o.he = n_he; o.ve = n_ve; o.ec = n_ec;
    return o;
  endfunction

  function automatic obs_t pack_p();
    obs_t o;
    o.x = p_x; o.y = p_y; o.act = p_act; o.rgb = p_rgb; o.fs = p_fs;
    o.lk = p_lk; o.he = p_he; o.ve = p_ve; o.ec = p_ec;
    return o;
  endfunction

  // reference model state: counters as plain ints, lock phase 0/1/2
  int   m_h = 0, m_v = 0, m_st = 0, m_ec = 0;
  bit   m_hp = 0, m_vp = 0, m_pend = 0, m_ha = 0, m_va = 0;
  obs_t m_o = '0, e_pop;
  obs_t exp_q[$];
  bit   pe_s;
  bit   hs_a, vs_a, hedge, vedge, e_fs, e_he, e_ve, e_act;

  // frame-level observations
  int samp_n = 0, last_fs_samp = 0, fs_int = -1;
  int fs_cnt = 0, he_cnt = 0, ve_cnt = 0, act_cnt = 0;
  int tl_seen = 0, tl_x = -1, tl_y = -1, br_seen = 0, br_x = -1, br_y = -1;

  always @(posedge clk) begin
    if (rst) begin
      m_h = 0; m_v = 0; m_st = 0; m_ec = 0;
      m_hp = 0; m_vp = 0; m_pend = 0; m_ha = 0; m_va = 0;
      m_o = '0;
    end else if (pix_en) begin
      hs_a  = !hs_n;
      vs_a  = !vs_n;
      hedge = hs_a && !m_hp;
      vedge = vs_a && !m_vp;
      e_fs = 0; e_he = 0; e_ve = 0;
      if (vedge) m_pend = 1;
      if (hedge) begin
        if (m_ha && m_h != HT - 1) e_he = 1;
        m_ha = 1;
        m_h  = 0;
        if (m_pend) begin
          e_fs = 1;
          if (m_va && m_v != VT - 1) e_ve = 1;
          m_va = 1; m_v = 0; m_pend = 0;
        end else if (m_v < 1023) begin
          m_v++;
        end
      end else if (m_h < 1023) begin
        m_h++;
      end
      m_hp = hs_a;
      m_vp = vs_a;
      if (e_he || e_ve) begin
        m_st = 0; m_ha = 0; m_va = 0;
        if (m_ec < 255) m_ec++;
      end else if (e_fs && m_st < 2) begin
        m_st++;
      end
      e_act = (m_st == 2) && m_h >= HS0 && m_h < HS0 + HA && m_v >= VS0 && m_v < VS0 + VA;
      m_o.act = e_act;
      m_o.x   = e_act ? 10'(m_h - HS0) : 10'd0;
      m_o.y   = e_act ? 10'(m_v - VS0) : 10'd0;
      m_o.rgb = e_act ? rgb : 3'd0;
      m_o.fs  = e_fs;
      m_o.he  = e_he;
      m_o.ve  = e_ve;
      m_o.lk  = (m_st == 2);
      m_o.ec  = 8'(m_ec);
    end else begin
      m_o.fs = 0; m_o.he = 0; m_o.ve = 0;
    end
    exp_q.push_back(m_o);
    pe_s = pix_en && !rst;
    #1;
    e_pop = exp_q.pop_front();
    cmp("model_n", pack_n(), e_pop);
    cmp("model_p", pack_p(), e_pop);
    if (pe_s) begin
      samp_n++;
      if (n_act) act_cnt++;
      if (n_act && n_rgb == 3'b100) begin tl_seen++; tl_x = int'(n_x); tl_y = int'(n_y); end
      if (n_act && n_rgb == 3'b001) begin br_seen++; br_x = int'(n_x); br_y = int'(n_y); end
    end
    if (n_fs) begin
      fs_cnt++;
      fs_int = samp_n - last_fs_samp;
      last_fs_samp = samp_n;
    end
    if (n_he) he_cnt++;
    if (n_ve) ve_cnt++;
  end

  // one accepted sample, preceded by random stall cycles carrying junk that must be ignored
  task automatic px(input bit hs, input bit vs, input logic [2:0] c);
    while ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      pix_en = 1'b0;
      hs_n = 1'($urandom); vs_n = 1'($urandom);
      hs_p = 1'($urandom); vs_p = 1'($urandom);
      rgb  = 3'($urandom);
    end
    @(negedge clk);
    pix_en = 1'b1;
    hs_n = !hs; vs_n = !vs; hs_p = hs; vs_p = vs;
    rgb = c;
  endtask

  task automatic send_line(input int l, input int h0, input int h1);
    logic [2:0] c;
    for (int h = h0; h < h1; h++) begin
      if (l == VS0 && h == HS0) c = 3'b100;
      else if (l == VS0 + VA - 1 && h == HS0 + HA - 1) c = 3'b001;
      else c = (h % 2 == 1) ? 3'b010 : 3'b110;
      px(h < HSY, l < VSY, c);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_obs();
    fs_cnt = 0; he_cnt = 0; ve_cnt = 0; act_cnt = 0;
    tl_seen = 0; br_seen = 0; tl_x = -1; tl_y = -1; br_x = -1; br_y = -1;
  endtask

  typedef struct {
    int lines;
    int bad_line;
    int bad_len;
    int lk;
    int ec;
    int fsi;
    int act;
    int he;
    int ve;
  } vec_t;

  task automatic apply_frame(input string tag, input vec_t v);
    clear_obs();
    for (int l = 0; l < v.lines; l++) send_line(l, 0, (l == v.bad_line) ? v.bad_len : HT);
    settle();
    chk({tag, "_locked"}, int'(n_lk), v.lk);
    chk({tag, "_err_count"}, int'(n_ec), v.ec);
    chk({tag, "_frame_starts"}, fs_cnt, 1);
    chk({tag, "_h_err_pulses"}, he_cnt, v.he);
    chk({tag, "_v_err_pulses"}, ve_cnt, v.ve);
    if (v.fsi >= 0) chk({tag, "_fs_interval"}, fs_int, v.fsi);
    if (v.act >= 0) chk({tag, "_active_pixels"}, act_cnt, v.act);
    if (v.act == HA * VA) begin
      chk({tag, "_tl_seen"}, tl_seen, 1);
      chk({tag, "_tl_x"}, tl_x, 0);
      chk({tag, "_tl_y"}, tl_y, 0);
      chk({tag, "_br_seen"}, br_seen, 1);
      chk({tag, "_br_x"}, br_x, HA - 1);
      chk({tag, "_br_y"}, br_y, VA - 1);
    end
  endtask

  localparam int FR = HT * VT;
  localparam int NA = HA * VA;
  vec_t tbl[10];

  initial begin
    //           lines bad  len     lk ec fsi     act  he ve
    tbl[0] = '{VT,     -1, HT,      0, 0, -1,     0,   0, 0};
    tbl[1] = '{VT,     -1, HT,      1, 0, FR,     NA,  0, 0};
    tbl[2] = '{VT,     -1, HT,      1, 0, FR,     NA,  0, 0};
    tbl[3] = '{VT,      8, HT - 1,  0, 1, FR,     -1,  1, 0};
    tbl[4] = '{VT,     -1, HT,      0, 1, FR - 1, 0,   0, 0};
    tbl[5] = '{VT,     -1, HT,      1, 1, FR,     NA,  0, 0};
    tbl[6] = '{VT + 1, -1, HT,      1, 1, FR,     NA,  0, 0};
    tbl[7] = '{VT,     -1, HT,      0, 2, FR + HT, 0,  0, 1};
    tbl[8] = '{VT,     -1, HT,      0, 2, FR,     0,   0, 0};
    tbl[9] = '{VT,     -1, HT,      1, 2, FR,     NA,  0, 0};

    repeat (3) @(negedge clk);
    #1;
    cmp("reset_n", pack_n(), '0);
    cmp("reset_p", pack_p(), '0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply_frame($sformatf("frame%0d", i), tbl[i]);

    // asynchronous reset in the middle of a line while locked
    for (int l = 0; l < 5; l++) send_line(l, 0, HT);
    send_line(5, 0, 10);
    @(negedge clk);
    pix_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    cmp("async_reset_n", pack_n(), '0);
    cmp("async_reset_p", pack_p(), '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_obs();
    send_line(5, 10, HT);
    for (int l = 6; l < VT; l++) send_line(l, 0, HT);
    settle();
    chk("post_reset_partial_locked", int'(n_lk), 0);
    chk("post_reset_partial_fs", fs_cnt, 0);
    apply_frame("relock_a", '{VT, -1, HT, 0, 0, -1, 0, 0, 0});
    apply_frame("relock_b", '{VT, -1, HT, 1, 0, FR, NA, 0, 0});

    // hsync held asserted far beyond a line: one error at the following edge
    clear_obs();
    for (int l = 0; l < 3; l++) send_line(l, 0, HT);
    for (int k = 0; k < 2000; k++) px(1'b1, 1'b0, 3'd0);
    for (int l = 4; l < VT; l++) send_line(l, 0, HT);
    settle();
    chk("stuck_h_err_pulses", he_cnt, 1);
    chk("stuck_locked", int'(n_lk), 0);
    chk("stuck_err_count", int'(n_ec), 1);

    // 2-sample lines: every second edge is checked and fails, 350 errors in total
    clear_obs();
    for (int k = 0; k < 700; k++) begin
      px(1'b1, 1'b0, 3'd0);
      px(1'b0, 1'b0, 3'd0);
    end
    settle();
    chk("sat_h_err_pulses", he_cnt, 350);
    chk("sat_err_count", int'(n_ec), 255);
    chk("sat_err_count_p", int'(p_ec), 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end
endmodule
